fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage. Owns the PC and drives the read port of the byte-addressed
//  instruction memory (1-cycle registered read, little-endian 32-bit word at raddr..raddr+3).
//  Captures each returned word with its PC into a 2-entry buffer and hands it to decode
//  over a valid/ready interface. Accepts branch/jump redirects from downstream.
// PARAMETERS
//  RESET_PC   32'h0  PC loaded on reset
//  MEM_BYTES  1376   instruction memory size in bytes; legal fetch PC range 0..MEM_BYTES-4
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  imem_raddr     out  32  byte read address to instruction memory (= pc_q)
//  imem_rdata     in   32  memory read data, valid the cycle after raddr was sampled
//  redirect_valid in   1   redirect request (highest priority)
//  redirect_pc    in   32  redirect target PC
//  inst_valid     out  1   instruction available to decode
//  inst_ready     in   1   decode accepts instruction
//  inst           out  32  instruction word
//  inst_pc        out  32  PC of inst
//  fetch_fault    out  1   sticky fault: misaligned or out-of-range PC
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc_q=RESET_PC, req_valid_q=0, buffer empty, state RUN;
//    inst_valid=0, inst=0, inst_pc=0, fetch_fault=0, imem_raddr=RESET_PC.
//  - Memory read is free-running; only req_valid_q/req_pc_q mark the word arriving next cycle as owned.
//  - Issue condition (RUN, no redirect): (count + req_valid_q - pop) < 2, pop = inst_valid&inst_ready.
//    On issue: req_valid_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+4. Else req_valid_q<=0, pc_q holds.
//  - Capture: req_valid_q=1 -> push {req_pc_q, imem_rdata} this cycle (word is lost if not
//    captured, hence the credit rule; push never overflows). Push+pop same cycle legal.
//  - Latency: PC issued at edge N -> inst_valid earliest after edge N+1. Throughput 1 inst/cycle with ready=1.
//  - inst_valid = buffer non-empty & !redirect_valid. inst/inst_pc held stable while valid & !ready.
//  - Redirect cycle: buffer flushed, req_valid_q<=0 (in-flight word discarded), no issue,
//    pc_q<=redirect_pc, state re-evaluated on redirect_pc; handshake in that cycle is not a transfer.
//    Redirect at cycle R -> redirect_pc issued R+1 -> inst_valid R+2.
//  - FSM: RUN -> FAULT when pc_q[1:0]!=0 or pc_q > MEM_BYTES-4 (checked before issue; faulting PC
//    never issued). FAULT: no issue, buffer drains normally, fetch_fault=1. FAULT -> RUN only on
//    redirect to a legal PC; redirect to illegal PC stays/enters FAULT next cycle.
//  - PC arithmetic 32-bit modulo; wrap past 32'hFFFF_FFFC unreachable since range check faults first.
//  - rst_n asserted mid-operation: all of above reset immediately, in-flight word dropped.
// STRUCTURE
//  - fetch_pkg: INSN_W=32, ADDR_W=32, INSN_BYTES=4, typedef fetch_state_e {RUN, FAULT},
//    typedef fetch_entry_t {pc, inst}.
//  - Sub-module fetch_skid_fifo: 2-entry fetch_entry_t FIFO with push/pop/flush, count, async reset.
//  - fetch_unit top: PC register, credit/issue logic, FSM, req tracking.
// TESTING
//  1. Words 0x11,0x22,0x33 at 0,4,8, RESET_PC=0, ready=1 -> first inst_valid 2 cycles after reset
//     release; inst_pc 0,4,8 back-to-back with inst 0x11,0x22,0x33.
//  2. Stream running, ready=0 for 5 cycles -> count never >2, no issue while full, resume gives
//     contiguous inst_pc with no drop/duplicate.
//  3. Redirect to 0x40 with one word in flight and one buffered -> both discarded, inst_valid=0 in
//     redirect cycle, next accepted inst_pc=0x40 at R+2.
//  4. Redirect to 0x42 -> fetch_fault=1 next cycle, imem request never tracked, inst_valid=0 once
//     drained; redirect to 0x10 -> fetch_fault=0, inst_pc=0x10 delivered.
//  5. Sequential run to PC 1372 -> 1372 delivered, PC 1376 faults, fetch_fault=1, no further inst.
//  6. rst_n pulsed low mid-stream (between edges) -> inst_valid=0 immediately; after release fetch
//     restarts at RESET_PC with no stale inst delivered.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;
    localparam int INSN_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    // One fetched instruction together with the PC it came from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: imem read port, redirect input and decode handshake.
interface fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0] imem_raddr;
    logic [INSN_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INSN_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_fault;

    // Fetch unit side.
    modport master (
        output imem_raddr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_raddr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry buffer of fetched {pc, inst} pairs with synchronous flush.
// Caller guarantees no push when full and no pop when empty.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);
    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;

    assign dout = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-based issue to a 1-cycle
// registered instruction memory, capture buffer and RUN/FAULT control.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                MEM_BYTES = 1376
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);
    localparam logic [ADDR_W-1:0] PC_MAX = ADDR_W'(MEM_BYTES - INSN_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;

    logic [1:0]        count;
    fetch_entry_t      head;
    fetch_entry_t      cap;
    logic              push, pop, flush;
    logic [2:0]        occ;

    function automatic logic pc_legal(input logic [ADDR_W-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc <= PC_MAX);
    endfunction

    // A redirect hides the buffer and kills the word returning this cycle.
    assign flush = bus.redirect_valid;
    assign push  = req_valid_q & ~bus.redirect_valid;
    assign pop   = bus.inst_valid & bus.inst_ready;
    assign cap   = '{pc: req_pc_q, inst: bus.imem_rdata};

    // Slots committed after this cycle: an outstanding request always lands,
    // so it must be reserved before the next one is sent.
    assign occ = {1'b0, count} + {2'b00, req_valid_q} - {2'b00, pop};

    fetch_skid_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cap),
        .dout  (head),
        .count (count)
    );

    assign bus.imem_raddr  = pc_q;
    assign bus.inst_valid  = (count != 2'd0) & ~bus.redirect_valid;
    assign bus.inst        = (count != 2'd0) ? head.inst : '0;
    assign bus.inst_pc     = (count != 2'd0) ? head.pc   : '0;
    assign bus.fetch_fault = (state_q == FAULT);

    // Next state, PC and request tracking; redirect has top priority.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = 1'b0;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            state_d = pc_legal(bus.redirect_pc) ? RUN : FAULT;
        end else begin
            case (state_q)
                RUN: begin
                    if (!pc_legal(pc_q)) begin
                        state_d = FAULT;
                    end else if (occ < 3'd2) begin
                        req_valid_d = 1'b1;
                        req_pc_d    = pc_q;
                        pc_d        = pc_q + ADDR_W'(INSN_BYTES);
                    end
                end
                FAULT: ;
                default: state_d = FAULT;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-array imem model and an
// expected-instruction scoreboard checked on every decode transfer.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int MEM_BYTES = 1376;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]   mem [MEM_BYTES];
    fetch_entry_t sb [$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           xfers = 0;
    logic         hold_v = 1'b0;
    fetch_entry_t hold_e;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        case (pc)
            32'd0:   return 32'h11;
            32'd4:   return 32'h22;
            32'd8:   return 32'h33;
            default: return 32'hC0DE_0000 | pc;
        endcase
    endfunction

    // Registered little-endian read, one cycle after the address is sampled.
    always @(posedge clk) begin
        int a;
        a = int'(bus.imem_raddr);
        if (bus.imem_raddr <= 32'(MEM_BYTES - 4))
            bus.imem_rdata <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        else
            bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_entry_t e;
            e.pc   = pc0 + 32'(4 * i);
            e.inst = word_at(e.pc);
            sb.push_back(e);
        end
    endtask

    // One clock: monitor at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n && hold_v && !bus.redirect_valid) begin
            chk("hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("hold_pc", bus.inst_pc, hold_e.pc);
            chk("hold_inst", bus.inst, hold_e.inst);
        end
        if (bus.inst_valid && bus.inst_ready) begin
            xfers++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_xfer: observed pc %h expected no transfer", bus.inst_pc);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                chk("xfer_pc", bus.inst_pc, e.pc);
                chk("xfer_inst", bus.inst, e.inst);
            end
        end
        hold_v = rst_n && bus.inst_valid && !bus.inst_ready;
        hold_e = '{pc: bus.inst_pc, inst: bus.inst};
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int          x0;
        logic [31:0] r;
        for (int a = 0; a < MEM_BYTES; a += 4) begin
            logic [31:0] w;
            w = word_at(32'(a));
            mem[a]   = w[7:0];
            mem[a+1] = w[15:8];
            mem[a+2] = w[23:16];
            mem[a+3] = w[31:24];
        end
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        #1 rst_n = 1'b0;
        ticks(2);

        // Reset state
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_pc", bus.inst_pc, 32'd0);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
        chk("rst_raddr", bus.imem_raddr, 32'd0);

        // First fetch latency and back-to-back stream
        expect_seq(32'h0, 24);
        rst_n = 1'b1;
        tick();
        chk("lat_e1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(bus.inst_valid), 32'd1);
        chk("lat_e2_pc", bus.inst_pc, 32'h0);
        chk("lat_e2_inst", bus.inst, 32'h11);
        x0 = xfers;
        ticks(3);
        chk("b2b_xfers", 32'(xfers - x0), 32'd3);

        // Decode stall: buffer fills, issue stops, then resumes in order
        bus.inst_ready = 1'b0;
        ticks(2);
        r = bus.imem_raddr;
        ticks(3);
        chk("stall_raddr", bus.imem_raddr, r);
        chk("stall_valid", 32'(bus.inst_valid), 32'd1);
        bus.inst_ready = 1'b1;
        x0 = xfers;
        ticks(6);
        chk("resume_xfers", 32'(xfers - x0), 32'd6);

        // Redirect with one word buffered and one in flight
        sb.delete();
        expect_seq(32'h40, 20);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1 chk("redir_cycle_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_r0_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("redir_r1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("redir_r2_valid", 32'(bus.inst_valid), 32'd1);
        chk("redir_r2_pc", bus.inst_pc, 32'h40);
        ticks(6);

        // Redirect to a misaligned PC, then recover
        sb.delete();
        redirect(32'h42);
        chk("mis_fault", 32'(bus.fetch_fault), 32'd1);
        ticks(4);
        chk("mis_valid", 32'(bus.inst_valid), 32'd0);
        chk("mis_fault_hold", 32'(bus.fetch_fault), 32'd1);
        chk("mis_raddr", bus.imem_raddr, 32'h42);
        expect_seq(32'h10, 20);
        redirect(32'h10);
        chk("rec_fault", 32'(bus.fetch_fault), 32'd0);
        ticks(2);
        chk("rec_valid", 32'(bus.inst_valid), 32'd1);
        chk("rec_pc", bus.inst_pc, 32'h10);
        ticks(3);

        // Run to the last legal word; the next PC faults
        sb.delete();
        expect_seq(32'd1344, 8);
        redirect(32'd1344);
        ticks(16);
        chk("end_drained", 32'(sb.size()), 32'd0);
        chk("end_fault", 32'(bus.fetch_fault), 32'd1);
        chk("end_valid", 32'(bus.inst_valid), 32'd0);
        chk("end_raddr", bus.imem_raddr, 32'd1376);

        // Asynchronous reset mid-stream
        sb.delete();
        expect_seq(32'h80, 20);
        redirect(32'h80);
        chk("pre_rst_fault", 32'(bus.fetch_fault), 32'd0);
        ticks(5);
        #2 rst_n = 1'b0;
        hold_v = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_raddr", bus.imem_raddr, 32'd0);
        chk("arst_pc", bus.inst_pc, 32'd0);
        sb.delete();
        expect_seq(32'h0, 12);
        ticks(2);
        rst_n = 1'b1;
        tick();
        chk("arst_e1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("arst_e2_valid", 32'(bus.inst_valid), 32'd1);
        chk("arst_e2_pc", bus.inst_pc, 32'h0);
        ticks(4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
